// File: rtl/step_ptr_ctr.sv
// Wrapping step pointer for the pattern register: advances on a tempo pulse,
// wraps at a programmable length and exposes its next-state for the read path.
module step_ptr_ctr #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             restart,
    input  logic [IDX_W-1:0] len_m1,
    output logic [IDX_W-1:0] idx_nx,
    output logic [IDX_W-1:0] step_idx,
    output logic             wrap
);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] step_idx_q;
    logic             wrap_q;
    logic             wrap_d;

    // Next pointer; ">=" also catches a length lowered below the current step.
    always_comb begin
        idx_nx = step_idx_q;
        wrap_d = 1'b0;
        if (restart) begin
            idx_nx = IDX_ZERO;
            wrap_d = 1'b0;
        end else if (advance) begin
            if (step_idx_q >= len_m1) begin
                idx_nx = IDX_ZERO;
                wrap_d = 1'b1;
            end else begin
                idx_nx = step_idx_q + IDX_ONE;
                wrap_d = 1'b0;
            end
        end else begin
            idx_nx = step_idx_q;
            wrap_d = 1'b0;
        end
    end

    // Pointer and wrap pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_idx_q <= IDX_ZERO;
            wrap_q     <= 1'b0;
        end else begin
            step_idx_q <= idx_nx;
            wrap_q     <= wrap_d;
        end
    end

    assign step_idx = step_idx_q;
    assign wrap     = wrap_q;

endmodule

// File: rtl/step_pattern_reg.sv
// Circular step pattern store with a tempo-driven pointer and a registered,
// write-forwarded readout of the current step word.
module step_pattern_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             restart,
    input  logic [IDX_W-1:0] len_m1,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    output logic [IDX_W-1:0] step_idx,
    output logic [WIDTH-1:0] step_data,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] WORD_RST = {WIDTH{1'b0}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] step_data_q;
    logic [WIDTH-1:0] step_data_d;
    logic [IDX_W-1:0] idx_nx;

    step_ptr_ctr #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ptr (
        .clk      (clk),
        .reset    (reset),
        .advance  (advance),
        .restart  (restart),
        .len_m1   (len_m1),
        .idx_nx   (idx_nx),
        .step_idx (step_idx),
        .wrap     (wrap)
    );

    // Forward a same-edge write so step_data never lags the stored word.
    always_comb begin
        step_data_d = mem_q[idx_nx];
        if (wr_en && (wr_idx == idx_nx)) begin
            step_data_d = wr_data;
        end else begin
            step_data_d = mem_q[idx_nx];
        end
    end

    // Pattern storage; writes are never blocked by playback.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WORD_RST;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Registered step word output.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_data_q <= WORD_RST;
        end else begin
            step_data_q <= step_data_d;
        end
    end

    assign step_data = step_data_q;

endmodule
